// File: rtl/i2c_frame_capture.sv
// I2C bus monitor: synchronises and deglitches scl/sda, decodes START/ADDR/DATA/STOP
// events into 12-bit records {kind, byte, ack, flag} and queues them in a FIFO.
module i2c_frame_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned MAX_BYTES   = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scl,
  input  logic                          sda,
  output logic [11:0]                   rec_data,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rec_count,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FCW   = $clog2(FILTER_LEN + 1);
  localparam logic [7:0]  MAX_B = 8'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_DATA, S_DACK} state_t;

  // Synchronisers, idle-high
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

  // Glitch filter: index 1 = scl, index 0 = sda
  logic [1:0]     raw_s, filt, filt_d;
  logic [FCW-1:0] fcnt [2];
  assign raw_s = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= raw_s[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  // START/STOP need scl high on both sides so a simultaneous scl/sda fall is not a START
  logic start_c, stop_c, rise_c, fall_c;
  assign start_c = filt[1] & filt_d[1] &  filt_d[0] & ~filt[0];
  assign stop_c  = filt[1] & filt_d[1] & ~filt_d[0] &  filt[0];
  assign rise_c  =  filt[1] & ~filt_d[1];
  assign fall_c  = ~filt[1] &  filt_d[1];

  // Frame decoder. A bit is sampled on scl rise but only committed on the following
  // fall, so the rise preceding a STOP or repeated START never counts as a data bit.
  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, byte_cnt;
  logic        trunc, pend, samp;
  logic        push_vld;
  logic [11:0] push_rec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      trunc    <= 1'b0;
      pend     <= 1'b0;
      samp     <= 1'b0;
      push_vld <= 1'b0;
      push_rec <= '0;
      busy     <= 1'b0;
    end else begin
      push_vld <= 1'b0;
      if (start_c) begin
        push_vld <= 1'b1;
        push_rec <= {2'b00, 8'h00, 1'b0, state != S_IDLE};
        state    <= S_ADDR;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        trunc    <= 1'b0;
        pend     <= 1'b0;
        busy     <= 1'b1;
      end else if (stop_c) begin
        pend <= 1'b0;
        if (state != S_IDLE) begin
          push_vld <= 1'b1;
          push_rec <= {2'b11, byte_cnt, trunc,
                       (bit_cnt != 3'd0) || (state == S_AACK) || (state == S_DACK)};
          state    <= S_IDLE;
          busy     <= 1'b0;
        end
      end else if (rise_c) begin
        pend <= 1'b1;
        samp <= filt[0];
      end else if (fall_c && pend) begin
        pend <= 1'b0;
        case (state)
          S_ADDR, S_DATA: begin
            shreg   <= {shreg[6:0], samp};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (state == S_ADDR) ? S_AACK : S_DACK;
          end
          S_AACK: begin
            push_vld <= 1'b1;
            push_rec <= {2'b01, shreg, ~samp, 1'b0};
            state    <= S_DATA;
          end
          S_DACK: begin
            if (byte_cnt < MAX_B) begin
              push_vld <= 1'b1;
              push_rec <= {2'b10, shreg, ~samp, 1'b0};
            end else begin
              trunc <= 1'b1;
            end
            if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            state <= S_DATA;
          end
          default: ;
        endcase
      end
    end
  end

  // Record FIFO; a push into a full FIFO still lands if the head is popped the same cycle
  logic [11:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop_c, full_c, wr_c;
  logic [CNT_W-1:0] count_nxt_c;

  assign pop_c       = rec_valid & rec_ready;
  assign full_c      = (rec_count == CNT_W'(FIFO_DEPTH));
  assign wr_c        = push_vld & (~full_c | pop_c);
  assign count_nxt_c = rec_count + CNT_W'(wr_c) - CNT_W'(pop_c);
  assign rec_data    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_count <= '0;
      rec_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      rec_count <= count_nxt_c;
      rec_valid <= (count_nxt_c != '0);
      if (push_vld && !wr_c) ovf <= 1'b1;
      else if (ovf_clr)      ovf <= 1'b0;
    end
  end

endmodule
